// File: rtl/modport_fifo_pkg.sv
// Shared constants and types for the single-clock modport FIFO.
package modport_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 16;

  // Address width for a power-of-two depth (equivalent to $clog2 for depth >= 2).
  function automatic int calc_addr_w(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < depth) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

  localparam int ADDR_W_DEF = calc_addr_w(DEPTH_DEF);

  typedef logic [ADDR_W_DEF:0] ptr_t;

endpackage

// File: rtl/modport_fifo_if.sv
// Producer/consumer handshake and status bus of the FIFO.
interface modport_fifo_if
  import modport_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
);
  localparam int ADDR_W = calc_addr_w(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  fifo_empty;
  logic [ADDR_W:0]       fifo_count;

  modport master (
    output wr_en, data_in, rd_en,
    input  fifo_full, data_out, fifo_empty, fifo_count
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output fifo_full, data_out, fifo_empty, fifo_count
  );
endinterface

// File: rtl/modport_fifo_mem.sv
// Simple dual-port RAM: synchronous write, synchronous registered read.
// The storage array is never cleared; only the read register resets.
module modport_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register: holds its value on any cycle without an accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= {DATA_WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end
endmodule

// File: rtl/modport_fifo.sv
// Single-clock FIFO: wrap-bit pointers, accept logic and flag/count decode
// around a dual-port RAM; ports grouped on modport_fifo_if.
module modport_fifo
  import modport_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic          wr_clk,
  input  logic          wr_rst,
  modport_fifo_if.slave bus
);
  localparam int ADDR_W = calc_addr_w(DEPTH);

  logic [ADDR_W:0] wr_ptr_r;
  logic [ADDR_W:0] rd_ptr_r;
  logic            full_s;
  logic            empty_s;
  logic            wr_accept_s;
  logic            rd_accept_s;

  // Status from the registered pointers; the MSB distinguishes full from empty.
  always_comb begin
    empty_s     = (wr_ptr_r == rd_ptr_r);
    full_s      = (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]) &&
                  (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]);
    wr_accept_s = bus.wr_en && !full_s;
    rd_accept_s = bus.rd_en && !empty_s;
  end

  assign bus.fifo_full  = full_s;
  assign bus.fifo_empty = empty_s;
  assign bus.fifo_count = wr_ptr_r - rd_ptr_r;

  // Pointer advance on accepted transfers.
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      wr_ptr_r <= {(ADDR_W+1){1'b0}};
      rd_ptr_r <= {(ADDR_W+1){1'b0}};
    end else begin
      if (wr_accept_s) begin
        wr_ptr_r <= wr_ptr_r + {{ADDR_W{1'b0}}, 1'b1};
      end
      if (rd_accept_s) begin
        rd_ptr_r <= rd_ptr_r + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  modport_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk     (wr_clk),
    .rst_n   (wr_rst),
    .wr_en   (wr_accept_s),
    .wr_addr (wr_ptr_r[ADDR_W-1:0]),
    .wr_data (bus.data_in),
    .rd_en   (rd_accept_s),
    .rd_addr (rd_ptr_r[ADDR_W-1:0]),
    .rd_data (bus.data_out)
  );
endmodule

// File: tb/tb_modport_fifo.sv
// Randomised and directed bench for modport_fifo against a queue model.
module tb_modport_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;

  modport_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  modport_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .wr_clk (clk),
    .wr_rst (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  logic [7:0]  model_q[$];
  logic [7:0]  exp_dout;
  logic [7:0]  out_q[$];
  bit          last_rd_ok;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  task automatic compare_all();
    chk("count", int'(bus.fifo_count), model_q.size());
    chk("full",  int'(bus.fifo_full),  (model_q.size() == DEPTH) ? 1 : 0);
    chk("empty", int'(bus.fifo_empty), (model_q.size() == 0) ? 1 : 0);
    chk("data_out", int'(bus.data_out), int'(exp_dout));
  endtask

  // One clock of stimulus: drive, let the edge happen, update model, compare.
  task automatic step(input bit we, input logic [7:0] din, input bit re);
    bit w_ok;
    bit r_ok;
    bus.wr_en   = we;
    bus.data_in = din;
    bus.rd_en   = re;
    @(posedge clk);
    w_ok = we && (model_q.size() < DEPTH);
    r_ok = re && (model_q.size() > 0);
    if (r_ok) exp_dout = model_q.pop_front();
    if (w_ok) model_q.push_back(din);
    last_rd_ok = r_ok;
    @(negedge clk);
    compare_all();
    if (r_ok) out_q.push_back(bus.data_out);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_empty"}, int'(bus.fifo_empty), 1);
    chk({tag, "_full"},  int'(bus.fifo_full),  0);
    chk({tag, "_count"}, int'(bus.fifo_count), 0);
    chk({tag, "_dout"},  int'(bus.data_out),   0);
  endtask

  initial begin
    int         produced;
    int         consumed;
    bit         saw_aa;
    logic [7:0] held;

    n_checks    = 0;
    n_fail      = 0;
    exp_dout    = 8'h00;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = 8'h00;
    rst_n       = 1'b0;
    #1;
    check_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Random warm-up traffic.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Mid-stream asynchronous reset, observed without a clock edge.
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0);
    #2;
    rst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_q.delete();
    exp_dout = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 0x01..0x10, then overflow attempt with 0xAA.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
    chk("fill_count", int'(bus.fifo_count), 16);
    chk("fill_full",  int'(bus.fifo_full),  1);
    step(1'b1, 8'hAA, 1'b0);
    chk("ovf_count", int'(bus.fifo_count), 16);
    chk("ovf_full",  int'(bus.fifo_full),  1);

    // Drain in order.
    saw_aa = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("drain_order", int'(bus.data_out), i);
      if (bus.data_out == 8'hAA) saw_aa = 1'b1;
    end
    chk("no_aa", int'(saw_aa), 0);
    chk("drain_empty", int'(bus.fifo_empty), 1);

    // Underflow: reads while empty leave data_out and count untouched.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("udf_dout",  int'(bus.data_out),   16);
      chk("udf_count", int'(bus.fifo_count), 0);
    end
    // rd_ptr unchanged: the next write/read pair must return that word.
    step(1'b1, 8'h5C, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("udf_ptr", int'(bus.data_out), 8'h5C);

    // Simultaneous read and write at count 5.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'h30 + i), 1'b1);
      chk("sim_count", int'(bus.fifo_count), 5);
      chk("sim_order", int'(bus.data_out), (i < 5) ? (8'h20 + i) : (8'h30 + i - 5));
    end
    while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1);
    held = 8'h39;
    chk("sim_last", int'(bus.data_out), int'(held));
    step(1'b1, 8'h77, 1'b1);
    chk("sim_empty_count", int'(bus.fifo_count), 1);
    chk("sim_empty_dout",  int'(bus.data_out), int'(held));
    step(1'b0, 8'h00, 1'b1);

    // Wrap: 40 words with interleaved reads, occupancy kept in 1..15.
    out_q.delete();
    produced = 0;
    step(1'b1, 8'h80, 1'b0);
    produced = 1;
    for (int cyc = 0; cyc < 2000 && produced < 40; cyc++) begin
      bit we;
      bit re;
      we = (model_q.size() < 15) && ($urandom_range(0, 3) != 0);
      re = (model_q.size() > 1) && ($urandom_range(0, 2) != 0);
      step(we, 8'(8'h80 + produced), re);
      if (we) produced++;
    end
    while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1);
    chk("wrap_produced", produced, 40);
    chk("wrap_emerged", out_q.size(), 40);
    consumed = 0;
    foreach (out_q[k]) begin
      chk("wrap_order", int'(out_q[k]), 8'h80 + k);
      consumed++;
    end

    // Final random soak with full/empty boundaries hit often.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
